dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's load/store path. It accepts one request at a time: a word address, store-aligned write data and a byte strobe. It applies byte-enabled writes to an internal word array, or returns the full 32-bit word for reads, after a configurable number of wait states. Sign extension and byte/half extraction remain in the load/store unit; this block works only on whole words masked by strobe.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; power of two.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response; 0 to 15.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: block can accept a request.
- `req_we`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, 32: byte address; word index = `req_addr[31:2]`; bits [1:0] are ignored.
- `req_wdata`, in, 32: store data, already byte-lane aligned.
- `req_strobe`, in, 4: byte enables; bit i writes `req_wdata[8i+7:8i]`.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_rdata`, out, 32: read word; 0 for writes.
- `rsp_err`, out, 1: access error (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- `req_ready` = (state == IDLE). `rsp_valid` = (state == RESP).
- IDLE:
  - On `req_valid & req_ready`, capture we, word index, wdata and strobe.
  - Go to WAIT with the counter loaded to `WAIT_STATES-1`, or straight to RESP when `WAIT_STATES` = 0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access and go to RESP.
- The access happens on the edge that enters RESP:
  - Write: each byte lane with its strobe bit set is updated; other lanes are unchanged. `rsp_rdata` is set to 0.
  - Read: `rsp_rdata` is loaded with the array word.
- RESP: outputs hold stable until `rsp_valid & rsp_ready`, then the FSM returns to IDLE.
- A write with strobe 4'b0000 changes no bytes but still produces a normal response.
- Word index width = log2(`DEPTH_WORDS`). Array contents are not reset.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Latency: a request accepted in cycle T gives `rsp_valid`=1 in cycle T+1+`WAIT_STATES`.
- Throughput: at most one request per 2+`WAIT_STATES` cycles when `rsp_ready` is held high.
  - `req_ready` is low in the cycle when the response is consumed.
  - A new request can be accepted in the next cycle.
- Read-after-write: a read accepted after a write's response has been consumed returns the written data.
- Response stall: if `rsp_ready`=0 indefinitely, the block stays in RESP and `req_ready` stays 0.
- Reset mid-operation:
  - Reset asserted in WAIT abandons the pending write; the array is unchanged.
  - Reset asserted in RESP drops the response.
  - Reset never corrupts a write that has already completed.

## Configuration
- `DMEM_BOUNDS_CHECK_EN` defined:
  - A word index ≥ `DEPTH_WORDS` (any set bit in `req_addr[31:2+log2(DEPTH_WORDS)]`) is an error.
  - On error, writes are suppressed, `rsp_rdata`=0 and `rsp_err`=1 for that response.
- `DMEM_BOUNDS_CHECK_EN` undefined:
  - Upper address bits are ignored and the index wraps modulo `DEPTH_WORDS`.
  - `rsp_err` is tied to 0.

## Test plan
- Reset, then write 0xDEADBEEF with strobe 4'b1111 at 0x10, then read 0x10 -> `rsp_rdata`=0xDEADBEEF, `rsp_err`=0, valid exactly 2 cycles after acceptance (`WAIT_STATES`=1).
- After the previous test, write 0x00AA0000 with strobe 4'b0100 at 0x12, then read 0x10 -> 0xDEAABEEF. Write 0x0000_1234 with strobe 4'b0011 at 0x10, then read -> 0xDEAA1234.
- Read at 0x10 with `rsp_ready` held 0 for 5 cycles -> `rsp_valid` and `rsp_rdata` stable and `req_ready`=0 throughout; one response is consumed when `rsp_ready` rises.
- `rst_n` pulsed low during the WAIT of a write of 0x11111111 at 0x20 (prior contents 0x55555555) -> read of 0x20 after reset returns 0x55555555; all outputs at reset values during reset.
- With `DMEM_BOUNDS_CHECK_EN` and `DEPTH_WORDS`=1024, write 0xFFFFFFFF at 0x1000 -> `rsp_err`=1, and word 0 is unchanged. Without the macro, the same write lands in word 0.
- `WAIT_STATES`=0, back-to-back reads with `rsp_ready`=1 -> responses every 2 cycles, each 1 cycle after acceptance.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-wide data memory responder with byte strobes and fixed wait states.
// Define DMEM_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strobe,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      strb_q;
    logic            oob_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            accept;
    logic            access;
    logic            mem_we;
    logic            req_oob;
    logic            acc_we;
    logic            acc_oob;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic [3:0]      acc_strb;

    logic [31:0]     mem [DEPTH_WORDS];

    logic [1:0]      unused_lsb;
    assign unused_lsb = req_addr[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oob = |(req_addr >> (AW + 2));
`else
    logic            unused_hi;
    assign unused_hi = ^(req_addr >> (AW + 2));
    assign req_oob   = 1'b0;
`endif

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid & req_ready;

    // With zero wait states the access happens on the accept edge,
    // before the captured request registers are loaded.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_oob   = req_oob;
            acc_idx   = req_addr[AW+1:2];
            acc_wdata = req_wdata;
            acc_strb  = req_strobe;
        end else begin
            acc_we    = we_q;
            acc_oob   = oob_q;
            acc_idx   = idx_q;
            acc_wdata = wdata_q;
            acc_strb  = strb_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (access) begin
            err_d   = acc_oob;
            rdata_d = (acc_we | acc_oob) ? 32'd0 : mem[acc_idx];
        end
    end

    assign mem_we = access & acc_we & ~acc_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            strb_q  <= 4'd0;
            oob_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+1:2];
            wdata_q <= req_wdata;
            strb_q  <= req_strobe;
            oob_q   <= req_oob;
        end
    end

    // Array is deliberately not reset; writes are gated by state,
    // which reset forces to idle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_strb[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array model.
// Covers strobes, stalls, mid-operation reset, bounds and zero-wait streaming.
module tb_dmem_responder;

    localparam int WS = 1;
    localparam int DW = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_strobe = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid0 = 1'b0;
    logic        req_ready0;
    logic        req_we0 = 1'b0;
    logic [31:0] req_addr0 = '0;
    logic [31:0] req_wdata0 = '0;
    logic [3:0]  req_strobe0 = '0;
    logic        rsp_valid0;
    logic        rsp_ready0 = 1'b0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DW];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strobe(req_strobe),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we0), .req_addr(req_addr0),
        .req_wdata(req_wdata0), .req_strobe(req_strobe0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: word index wraps, out-of-range flagged if enabled.
    task automatic m_access(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            output logic [31:0] rd, output logic err);
        int idx;
        bit oob;
        idx = int'((a >> 2) % DW);
`ifdef DMEM_BOUNDS_CHECK_EN
        oob = ((a >> 2) >= DW);
`else
        oob = 1'b0;
`endif
        rd  = 32'd0;
        err = oob;
        if (!oob) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end else begin
                rd = ref_mem[idx];
            end
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int stall, output logic [31:0] rd,
                        output logic er, output int lat);
        int n;
        logic [31:0] hold;
        req_valid = 1'b1; req_we = we; req_addr = a;
        req_wdata = wd; req_strobe = st; rsp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("resp_ready_low", 32'(req_ready), 32'd0);
        hold = rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, hold);
            chk("stall_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("consumed", 32'({rsp_valid, req_ready}), 32'd1);
    endtask

    task automatic run(input string tag, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input int stall,
                       output logic [31:0] rd);
        logic [31:0] erd;
        logic er, eer;
        int lat;
        xact(we, a, wd, st, stall, rd, er, lat);
        m_access(we, a, wd, st, erd, eer);
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, 32'(er), 32'(eer));
        chk({tag, "_lat"}, 32'(lat), 32'(1 + WS));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] d0 [4];
        logic [31:0] exp0;
        int k;
        int n;

        #12;
        chk_reset_outs("reset");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outs("post_reset");

        for (int i = 0; i < 16; i++)
            run("init", 1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd);

        run("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        run("t1_rd", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("t1_const", rd, 32'hDEADBEEF);

        run("t2_wr_b2", 1'b1, 32'h12, 32'h00AA0000, 4'b0100, 0, rd);
        run("t2_rd_a", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("t2_const_a", rd, 32'hDEAABEEF);
        run("t2_wr_h0", 1'b1, 32'h10, 32'h00001234, 4'b0011, 0, rd);
        run("t2_rd_b", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("t2_const_b", rd, 32'hDEAA1234);
        run("t2_wr_s0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd);
        run("t2_rd_c", 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("t2_const_c", rd, 32'hDEAA1234);

        run("t3_stall", 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);
        chk("t3_const", rd, 32'hDEAA1234);

        run("t4_pre", 1'b1, 32'h20, 32'h55555555, 4'hF, 0, rd);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h11111111; req_strobe = 4'hF;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t4_in_wait", 32'({req_ready, rsp_valid}), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("t4_rst");
        @(posedge clk); #1;
        chk_reset_outs("t4_rst_hold");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run("t4_rd", 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        chk("t4_const", rd, 32'h55555555);

        run("t5_w0", 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, rd);
        run("t5_oob", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd);
        run("t5_rd0", 1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
`ifdef DMEM_BOUNDS_CHECK_EN
        exp0 = 32'h0BADF00D;
`else
        exp0 = 32'hFFFFFFFF;
`endif
        chk("t5_const", rd, exp0);

        for (int i = 0; i < 4; i++) d0[i] = $urandom;
        req_valid0 = 1'b1; rsp_ready0 = 1'b1; req_strobe0 = 4'hF;
        for (int c = 0; c < 16; c++) begin
            k = c / 2;
            if (c % 2 == 0) begin
                req_we0 = (k < 4);
                req_addr0 = 32'((k % 4) * 4);
                req_wdata0 = d0[k % 4];
            end
            chk("b2b_ready", 32'(req_ready0), 32'(c % 2 == 0));
            chk("b2b_valid", 32'(rsp_valid0), 32'(c % 2 == 1));
            if (c % 2 == 1)
                chk("b2b_rdata", rsp_rdata0, (k < 4) ? 32'd0 : d0[k % 4]);
            @(posedge clk); #1;
        end
        req_valid0 = 1'b0; rsp_ready0 = 1'b0;

        for (int i = 0; i < 80; i++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
            run("rand", 1'($urandom_range(0, 1)), a, $urandom,
                4'($urandom), int'($urandom_range(0, 2)), rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
